// File: rtl/t_inst_stim.sv
// Stimulus driver and self-checker for the t_inst_b leaf: LFSR-driven inputs, inverted-output checks.
// Optional T_INST_STIM_STOP_EN: report the first mismatching cycle and $stop (simulation only).
module t_inst_stim #(
  parameter int unsigned NUM_CYCLES = 20,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  output logic         i_seq,
  output logic         i_com,
  output logic [1:0]   i2_com,
  output logic [127:0] wide_for_trace,
  output logic [127:0] wide_for_trace_2,
  input  logic         o_seq_d1r,
  input  logic         o_com,
  input  logic [1:0]   o2_com,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic [15:0]  cyc_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] LAST_CYC  = 16'(NUM_CYCLES - 1);

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] r;
    if (v[0]) begin
      r = (v >> 1) ^ LFSR_TAPS;
    end else begin
      r = v >> 1;
    end
    return r;
  endfunction

  state_t         state_r, state_s;
  logic [31:0]    lfsr_r, lfsr_s;
  logic           stim_ld_s;
  logic [31:0]    stim_src_s;
  logic           i_seq_r, i_seq_s;
  logic           i_com_r, i_com_s;
  logic [1:0]     i2_com_r, i2_com_s;
  logic [127:0]   wide_r, wide_s;
  logic [127:0]   wide2_r, wide2_s;
  logic           seq_exp_r, seq_exp_s;
  logic           seq_vld_r, seq_vld_s;
  logic [7:0]     err_cnt_r, err_cnt_s, err_upd_s;
  logic [15:0]    cyc_cnt_r, cyc_cnt_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           pass_r, pass_s;
  logic           com_err_s, com2_err_s, comb_err_s, seq_err_s;

  assign com_err_s  = (state_r == ST_RUN) && (o_com != ~i_com_r);
  assign com2_err_s = (state_r == ST_RUN) && (o2_com != ~i2_com_r);
  assign comb_err_s = com_err_s || com2_err_s;
  assign seq_err_s  = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && seq_vld_r &&
                      (o_seq_d1r != seq_exp_r);
  assign err_upd_s  = ((comb_err_s || seq_err_s) && (err_cnt_r != 8'hFF)) ?
                      (err_cnt_r + 8'd1) : err_cnt_r;

  // Next-state and next-register values for the test sequencer
  always_comb begin
    state_s    = state_r;
    lfsr_s     = lfsr_r;
    stim_ld_s  = 1'b0;
    stim_src_s = lfsr_r;
    seq_exp_s  = seq_exp_r;
    seq_vld_s  = seq_vld_r;
    err_cnt_s  = err_cnt_r;
    cyc_cnt_s  = cyc_cnt_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stim_ld_s  = 1'b1;
          stim_src_s = SEED_EFF;
          lfsr_s     = lfsr_next(SEED_EFF);
          err_cnt_s  = 8'd0;
          cyc_cnt_s  = 16'd0;
          seq_vld_s  = 1'b0;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          pass_s     = 1'b0;
          state_s    = ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        stim_ld_s  = 1'b1;
        stim_src_s = lfsr_r;
        lfsr_s     = lfsr_next(lfsr_r);
        cyc_cnt_s  = cyc_cnt_r + 16'd1;
        seq_exp_s  = ~i_seq_r;
        seq_vld_s  = 1'b1;
        err_cnt_s  = err_upd_s;
        if (cyc_cnt_r == LAST_CYC) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        err_cnt_s = err_upd_s;
        busy_s    = 1'b0;
        done_s    = 1'b1;
        pass_s    = (err_upd_s == 8'd0);
        state_s   = ST_DONE;
      end
      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Stimulus fan-out from the selected LFSR word
  always_comb begin
    i_seq_s  = i_seq_r;
    i_com_s  = i_com_r;
    i2_com_s = i2_com_r;
    wide_s   = wide_r;
    wide2_s  = wide2_r;
    if (stim_ld_s) begin
      i_seq_s  = stim_src_s[0];
      i_com_s  = stim_src_s[1];
      i2_com_s = stim_src_s[3:2];
      wide_s   = {4{stim_src_s}};
      wide2_s  = ~{4{stim_src_s}};
    end else begin
      i_seq_s  = i_seq_r;
      i_com_s  = i_com_r;
      i2_com_s = i2_com_r;
      wide_s   = wide_r;
      wide2_s  = wide2_r;
    end
  end

  // State, LFSR, stimulus and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= SEED_EFF;
      i_seq_r   <= 1'b0;
      i_com_r   <= 1'b0;
      i2_com_r  <= 2'b00;
      wide_r    <= 128'd0;
      wide2_r   <= 128'd0;
      seq_exp_r <= 1'b0;
      seq_vld_r <= 1'b0;
      err_cnt_r <= 8'd0;
      cyc_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      lfsr_r    <= lfsr_s;
      i_seq_r   <= i_seq_s;
      i_com_r   <= i_com_s;
      i2_com_r  <= i2_com_s;
      wide_r    <= wide_s;
      wide2_r   <= wide2_s;
      seq_exp_r <= seq_exp_s;
      seq_vld_r <= seq_vld_s;
      err_cnt_r <= err_cnt_s;
      cyc_cnt_r <= cyc_cnt_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
    end
  end

  assign i_seq            = i_seq_r;
  assign i_com            = i_com_r;
  assign i2_com           = i2_com_r;
  assign wide_for_trace   = wide_r;
  assign wide_for_trace_2 = wide2_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_cnt_r;
  assign cyc_count        = cyc_cnt_r;

`ifdef T_INST_STIM_STOP_EN
  logic [2:0]  stop_fld_r;
  logic [15:0] stop_cyc_r;
  logic        stop_seen_r;

  // Capture the failing fields at the edge so the report follows the err_count update
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      stop_fld_r <= 3'b000;
      stop_cyc_r <= 16'd0;
    end else begin
      stop_fld_r <= {seq_err_s, com_err_s, com2_err_s};
      stop_cyc_r <= cyc_cnt_r;
    end
  end

  // Report the first mismatching cycle and halt, later in the same clock period
  always @(negedge clk) begin
    if (!reset_l) begin
      stop_seen_r = 1'b0;
    end else if ((stop_fld_r != 3'b000) && !stop_seen_r) begin
      stop_seen_r = 1'b1;
      $write("%%Error: cyc=%0d%s%s%s mismatch\n", stop_cyc_r,
             stop_fld_r[2] ? " seq" : "", stop_fld_r[1] ? " com" : "",
             stop_fld_r[0] ? " com2" : "");
      $stop;
    end
  end
`else
`endif

endmodule

// File: tb/tb_t_inst_stim.sv
// Bench for t_inst_stim: two instances (20 and 300 cycles) against a leaf model with injectable faults.
module tb_t_inst_stim;
  localparam int N_A = 20;
  localparam int N_B = 300;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  logic         start_w [2];
  logic [1:0]   fault_w [2];
  logic         i_seq_w [2];
  logic         i_com_w [2];
  logic [1:0]   i2_com_w [2];
  logic [127:0] wide_w [2];
  logic [127:0] wide2_w [2];
  logic         o_seq_w [2];
  logic         o_com_w [2];
  logic [1:0]   o2_com_w [2];
  logic         seq_q [2];
  logic         busy_w [2];
  logic         done_w [2];
  logic         pass_w [2];
  logic [7:0]   err_w [2];
  logic [15:0]  cyc_w [2];

  t_inst_stim #(.NUM_CYCLES(N_A), .SEED(32'h0000_0001)) u_dut_a (
    .clk(clk), .reset_l(reset_l), .start(start_w[0]),
    .i_seq(i_seq_w[0]), .i_com(i_com_w[0]), .i2_com(i2_com_w[0]),
    .wide_for_trace(wide_w[0]), .wide_for_trace_2(wide2_w[0]),
    .o_seq_d1r(o_seq_w[0]), .o_com(o_com_w[0]), .o2_com(o2_com_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .cyc_count(cyc_w[0]));

  // SEED of zero must behave like SEED of one
  t_inst_stim #(.NUM_CYCLES(N_B), .SEED(32'h0000_0000)) u_dut_b (
    .clk(clk), .reset_l(reset_l), .start(start_w[1]),
    .i_seq(i_seq_w[1]), .i_com(i_com_w[1]), .i2_com(i2_com_w[1]),
    .wide_for_trace(wide_w[1]), .wide_for_trace_2(wide2_w[1]),
    .o_seq_d1r(o_seq_w[1]), .o_com(o_com_w[1]), .o2_com(o2_com_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .cyc_count(cyc_w[1]));

  // Leaf model; fault 1: o_seq_d1r combinational, 2: o2_com stuck 00, 3: o_com not inverted
  always @(posedge clk) begin
    seq_q[0] <= ~i_seq_w[0];
    seq_q[1] <= ~i_seq_w[1];
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      o_seq_w[i]  = (fault_w[i] == 2'd1) ? ~i_seq_w[i] : seq_q[i];
      o_com_w[i]  = (fault_w[i] == 2'd3) ? i_com_w[i] : ~i_com_w[i];
      o2_com_w[i] = (fault_w[i] == 2'd2) ? 2'b00 : ~i2_com_w[i];
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: LFSR word list plus start time per instance
  logic [31:0] lw [0:300];
  int          ec = 0;
  int          t_m [2];
  bit          started_m [2];
  logic [1:0]  fault_m [2];

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] taps;
    taps = 32'h8020_0003;
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  function automatic int n_of(input int i);
    return (i == 0) ? N_A : N_B;
  endfunction

  // Errors accumulated after the first j edges of a run: comb checks on edges 1..n, seq on 2..n+1
  function automatic int err_at(input int i, input int j);
    int cnt, n, last;
    bit e;
    cnt  = 0;
    n    = n_of(i);
    last = (j < n + 1) ? j : n + 1;
    for (int k = 1; k <= last; k++) begin
      e = 1'b0;
      if (k <= n) begin
        if (fault_m[i] == 2'd3) e = 1'b1;
        if (fault_m[i] == 2'd2 && lw[k-1][3:2] != 2'b11) e = 1'b1;
      end
      if (k >= 2 && fault_m[i] == 2'd1 && lw[k-1][0] != lw[k-2][0]) e = 1'b1;
      if (e && cnt < 255) cnt++;
    end
    return cnt;
  endfunction

  always @(posedge clk) begin
    ec <= ec + 1;
    for (int i = 0; i < 2; i++) begin
      if (!reset_l) begin
        started_m[i] <= 1'b0;
      end else if (start_w[i] && (!started_m[i] || (ec + 1 - t_m[i]) >= n_of(i) + 2)) begin
        t_m[i]       <= ec + 1;
        started_m[i] <= 1'b1;
        fault_m[i]   <= fault_w[i];
      end
    end
  end

  logic [31:0]  m_v;
  logic [127:0] m_wide, m_wide2;
  logic         m_busy, m_done, m_pass;
  logic [7:0]   m_err;
  logic [15:0]  m_cyc;
  int           m_j, m_idx;
  string        m_p;

  // Compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        m_p = (i == 0) ? "a" : "b";
        if (!started_m[i]) begin
          m_v = 32'd0; m_wide = 128'd0; m_wide2 = 128'd0;
          m_busy = 1'b0; m_done = 1'b0; m_err = 8'd0; m_cyc = 16'd0;
        end else begin
          m_j    = ec - t_m[i];
          m_idx  = (m_j < n_of(i)) ? m_j : n_of(i);
          m_v    = lw[m_idx];
          m_wide = {4{m_v}};
          m_wide2 = ~{4{m_v}};
          m_busy = (m_j <= n_of(i));
          m_done = (m_j >= n_of(i) + 1);
          m_err  = 8'(err_at(i, m_j));
          m_cyc  = 16'(m_idx);
        end
        m_pass = m_done && (m_err == 8'd0);
        chk({m_p, ".i_seq"}, 128'(i_seq_w[i]), 128'(m_v[0]));
        chk({m_p, ".i_com"}, 128'(i_com_w[i]), 128'(m_v[1]));
        chk({m_p, ".i2_com"}, 128'(i2_com_w[i]), 128'(m_v[3:2]));
        chk({m_p, ".wide"}, wide_w[i], m_wide);
        chk({m_p, ".wide2"}, wide2_w[i], m_wide2);
        chk({m_p, ".busy"}, 128'(busy_w[i]), 128'(m_busy));
        chk({m_p, ".done"}, 128'(done_w[i]), 128'(m_done));
        chk({m_p, ".pass"}, 128'(pass_w[i]), 128'(m_pass));
        chk({m_p, ".err_count"}, 128'(err_w[i]), 128'(m_err));
        chk({m_p, ".cyc_count"}, 128'(cyc_w[i]), 128'(m_cyc));
      end
    end
  end

  task automatic wait_ec(input int n);
    while (ec < n) @(negedge clk);
  endtask

  logic [127:0] lit_wide;
  int           t0;

  initial begin
    reset_l = 1'b0;
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    fault_w[0] = 2'd0; fault_w[1] = 2'd0;
    lw[0] = 32'h0000_0001;
    for (int k = 1; k <= 300; k++) lw[k] = lfsr_step(lw[k-1]);
    lit_wide = 128'h00000001_00000001_00000001_00000001;

    wait_ec(1);
    chk_en = 1'b1;
    chk("model.lfsr1", 128'(lw[1]), 128'h8020_0003);
    chk("model.lfsr2", 128'(lw[2]), 128'hC030_0002);
    chk("model.lfsr3", 128'(lw[3]), 128'h6018_0001);
    chk("reset.busy", 128'(busy_w[0]), 128'd0);

    // Start sampled at edge 3
    wait_ec(2); reset_l = 1'b1; start_w[0] = 1'b1;
    wait_ec(3); start_w[0] = 1'b0;
    chk("first.i_seq", 128'(i_seq_w[0]), 128'd1);
    chk("first.i_com", 128'(i_com_w[0]), 128'd0);
    chk("first.i2_com", 128'(i2_com_w[0]), 128'd0);
    chk("first.wide", wide_w[0], lit_wide);
    chk("first.wide2", wide2_w[0], ~lit_wide);
    chk("first.busy", 128'(busy_w[0]), 128'd1);

    // Start during RUN must be ignored
    wait_ec(10); start_w[0] = 1'b1;
    wait_ec(11); start_w[0] = 1'b0;
    wait_ec(23);
    chk("edge24.busy", 128'(busy_w[0]), 128'd1);
    chk("edge24.done", 128'(done_w[0]), 128'd0);
    wait_ec(24);
    chk("edge25.done", 128'(done_w[0]), 128'd1);
    chk("edge25.pass", 128'(pass_w[0]), 128'd1);
    chk("edge25.busy", 128'(busy_w[0]), 128'd0);
    chk("edge25.err", 128'(err_w[0]), 128'd0);
    chk("edge25.cyc", 128'(cyc_w[0]), 128'd20);

    // Replay from DONE
    wait_ec(26); start_w[0] = 1'b1;
    wait_ec(27); start_w[0] = 1'b0;
    wait_ec(48);
    chk("replay.done", 128'(done_w[0]), 128'd1);
    chk("replay.pass", 128'(pass_w[0]), 128'd1);
    chk("replay.cyc", 128'(cyc_w[0]), 128'd20);

    // Combinational o_seq_d1r must be caught
    fault_w[0] = 2'd1;
    wait_ec(50); start_w[0] = 1'b1;
    wait_ec(51); start_w[0] = 1'b0;
    wait_ec(72);
    chk("seqfault.done", 128'(done_w[0]), 128'd1);
    chk("seqfault.pass", 128'(pass_w[0]), 128'd0);
    chk("seqfault.err_nonzero", 128'(err_w[0] != 8'd0), 128'd1);

    // Reset mid-run at cyc_count 5
    fault_w[0] = 2'd0;
    wait_ec(74); start_w[0] = 1'b1;
    wait_ec(75); start_w[0] = 1'b0;
    for (int k = 0; k < 20; k++) if (cyc_w[0] != 16'd5) @(negedge clk);
    chk("midreset.reach5", 128'(cyc_w[0]), 128'd5);
    reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    chk("midreset.busy", 128'(busy_w[0]), 128'd0);
    chk("midreset.cyc", 128'(cyc_w[0]), 128'd0);
    chk("midreset.err", 128'(err_w[0]), 128'd0);
    chk("midreset.i_seq", 128'(i_seq_w[0]), 128'd0);
    chk("midreset.wide", wide_w[0], 128'd0);
    chk("midreset.wide2", wide2_w[0], 128'd0);

    // Long instance: o2_com stuck at 00
    fault_w[1] = 2'd2;
    start_w[1] = 1'b1; @(negedge clk); start_w[1] = 1'b0;
    t0 = ec;
    wait_ec(t0 + N_B + 1);
    chk("stuck2.done", 128'(done_w[1]), 128'd1);
    chk("stuck2.pass", 128'(pass_w[1]), 128'd0);

    // Long instance: every RUN cycle fails, count saturates
    fault_w[1] = 2'd3;
    @(negedge clk);
    start_w[1] = 1'b1; @(negedge clk); start_w[1] = 1'b0;
    t0 = ec;
    wait_ec(t0 + N_B + 1);
    chk("sat.done", 128'(done_w[1]), 128'd1);
    chk("sat.err", 128'(err_w[1]), 128'd255);
    chk("sat.pass", 128'(pass_w[1]), 128'd0);
    chk("sat.cyc", 128'(cyc_w[1]), 128'd300);

    wait_ec(ec + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
